// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : piso_serializer
//  Description : Parallel-in / serial-out stage. Accepts one WIDTH-bit word
//                over a valid/ready handshake, then shifts it out one bit per
//                ser_en strobe and pulses done after the final bit.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1      rising-edge clock
//    reset      in   1      asynchronous, active-high reset
//    par_valid  in   1      word on par_data is valid
//    par_data   in   WIDTH  parallel word, sampled only on acceptance
//    par_ready  out  1      block can accept a word (combinational)
//    ser_en     in   1      shift strobe; current bit consumed when high
//    ser_out    out  1      serial data bit (registered)
//    ser_valid  out  1      ser_out carries a payload bit (registered)
//    busy       out  1      high while shifting and in the done cycle
//    done       out  1      one-cycle pulse after the final bit
// ============================================================================
module piso_serializer #(
   parameter int WIDTH      = 8,
   parameter bit MSB_FIRST  = 1'b1,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             par_valid,
   input  logic [WIDTH-1:0] par_data,
   output logic             par_ready,
   input  logic             ser_en,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             busy,
   output logic             done
);

   localparam int                CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   sreg, sreg_nxt;
   logic [CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
   logic               ser_out_nxt, ser_valid_nxt, busy_nxt, done_nxt;

   // Bit-order dependent pieces: the shifted register image, the bit that
   // appears on ser_out right after acceptance, and the bit that appears
   // after the next shift.
   logic [WIDTH-1:0]   shifted;
   logic               first_bit;
   logic               next_bit;

   generate
      if (MSB_FIRST) begin : g_msb_first
         assign shifted   = {sreg[WIDTH-2:0], 1'b0};
         assign first_bit = par_data[WIDTH-1];
         assign next_bit  = shifted[WIDTH-1];
      end else begin : g_lsb_first
         assign shifted   = {1'b0, sreg[WIDTH-1:1]};
         assign first_bit = par_data[0];
         assign next_bit  = shifted[0];
      end
   endgenerate

   // Ready is combinational so the upstream register sees it in the very
   // first cycle after reset release; it is forced low while reset is held.
   assign par_ready = (state == S_IDLE) && !reset;

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         sreg      <= '0;
         bit_cnt   <= '0;
         ser_out   <= IDLE_LEVEL;
         ser_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         sreg      <= sreg_nxt;
         bit_cnt   <= bit_cnt_nxt;
         ser_out   <= ser_out_nxt;
         ser_valid <= ser_valid_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_nxt     = state;
      sreg_nxt      = sreg;
      bit_cnt_nxt   = bit_cnt;
      ser_out_nxt   = ser_out;
      ser_valid_nxt = ser_valid;
      busy_nxt      = busy;
      done_nxt      = 1'b0;

      case (state)
         S_IDLE: begin
            if (par_valid) begin
               // First bit is presented from the acceptance edge onward.
               state_nxt     = S_SHIFT;
               sreg_nxt      = par_data;
               bit_cnt_nxt   = CNT_LOAD;
               ser_out_nxt   = first_bit;
               ser_valid_nxt = 1'b1;
               busy_nxt      = 1'b1;
            end
         end

         S_SHIFT: begin
            if (ser_en) begin
               sreg_nxt    = shifted;
               bit_cnt_nxt = bit_cnt - CNT_LAST;
               if (bit_cnt == CNT_LAST) begin
                  // Last bit consumed: line returns to idle level, busy
                  // is kept for the single done cycle.
                  state_nxt     = S_DONE;
                  ser_out_nxt   = IDLE_LEVEL;
                  ser_valid_nxt = 1'b0;
                  done_nxt      = 1'b1;
               end else begin
                  ser_out_nxt = next_bit;
               end
            end
         end

         S_DONE: begin
            state_nxt     = S_IDLE;
            ser_out_nxt   = IDLE_LEVEL;
            ser_valid_nxt = 1'b0;
            busy_nxt      = 1'b0;
         end

         default: begin
            state_nxt     = S_IDLE;
            ser_out_nxt   = IDLE_LEVEL;
            ser_valid_nxt = 1'b0;
            busy_nxt      = 1'b0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piso_serializer
//  Description : Self-checking bench for piso_serializer. Two instances share
//                all inputs, one MSB-first and one LSB-first, and are checked
//                every cycle against a word-level reference of the stream.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_piso_serializer;

   localparam int W = 8;

   logic         clk       = 1'b0;
   logic         reset     = 1'b1;
   logic         par_valid = 1'b1;
   logic [W-1:0] par_data  = '0;
   logic         ser_en    = 1'b0;

   logic m_ready, m_out, m_valid, m_busy, m_done;
   logic l_ready, l_out, l_valid, l_busy, l_done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_msb (
      .clk       (clk),
      .reset     (reset),
      .par_valid (par_valid),
      .par_data  (par_data),
      .par_ready (m_ready),
      .ser_en    (ser_en),
      .ser_out   (m_out),
      .ser_valid (m_valid),
      .busy      (m_busy),
      .done      (m_done)
   );

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
      .clk       (clk),
      .reset     (reset),
      .par_valid (par_valid),
      .par_data  (par_data),
      .par_ready (l_ready),
      .ser_en    (ser_en),
      .ser_out   (l_out),
      .ser_valid (l_valid),
      .busy      (l_busy),
      .done      (l_done)
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // i-th transmitted bit of a word, straight from the bit-order definition
   function automatic logic stream_bit(input logic [W-1:0] w, input int i, input bit msb);
      return msb ? w[W-1-i] : w[i];
   endfunction

   task automatic chk_all(input string tag, input logic rdy, input logic vld,
                          input logic bsy, input logic dn, input logic om, input logic ol);
      chk($sformatf("%s.msb.ready", tag), m_ready, rdy);
      chk($sformatf("%s.msb.valid", tag), m_valid, vld);
      chk($sformatf("%s.msb.busy",  tag), m_busy,  bsy);
      chk($sformatf("%s.msb.done",  tag), m_done,  dn);
      chk($sformatf("%s.msb.out",   tag), m_out,   om);
      chk($sformatf("%s.lsb.ready", tag), l_ready, rdy);
      chk($sformatf("%s.lsb.valid", tag), l_valid, vld);
      chk($sformatf("%s.lsb.busy",  tag), l_busy,  bsy);
      chk($sformatf("%s.lsb.done",  tag), l_done,  dn);
      chk($sformatf("%s.lsb.out",   tag), l_out,   ol);
   endtask

   // Called at a falling edge with both instances idle. mode: 0 = ser_en
   // always high, N>0 = high every Nth cycle, -1 = random. abort_at >= 0
   // asserts reset once that many bits have been consumed.
   task automatic send(input logic [W-1:0] word, input int mode, input bit hold_valid,
                       input logic [W-1:0] junk, input int abort_at);
      int   idx = 0;
      int   cyc = 0;
      logic en;
      chk_all("pre_accept", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      par_valid = 1'b1;
      par_data  = word;
      @(negedge clk);
      par_valid = hold_valid;
      if (hold_valid) par_data = junk;
      while (idx < W) begin
         chk_all($sformatf("bit%0d", idx), 1'b0, 1'b1, 1'b1, 1'b0,
                 stream_bit(word, idx, 1'b1), stream_bit(word, idx, 1'b0));
         if (idx == abort_at) begin
            reset = 1'b1;
            #1;
            chk_all("abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            ser_en    = 1'b0;
            par_valid = 1'b0;
            @(negedge clk);
            chk_all("in_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            reset = 1'b0;
            #1;
            chk_all("post_reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            return;
         end
         if (mode == 0)      en = 1'b1;
         else if (mode < 0)  en = 1'($urandom_range(0, 1));
         else                en = ((cyc % mode) == (mode - 1));
         ser_en = en;
         cyc++;
         @(negedge clk);
         if (en) idx++;
         if (cyc > 40 * W) begin
            chk("timeout", logic'(idx == W), 1'b1);
            ser_en = 1'b0;
            return;
         end
      end
      chk_all("done", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      ser_en = 1'b1;                 // must be ignored in the done cycle
      @(negedge clk);
      ser_en = 1'b0;
      chk_all("idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      // Reset held 3 cycles with par_valid asserted
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_all("reset_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      par_valid = 1'b0;
      reset     = 1'b0;
      #1;
      chk_all("reset_release", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk_all("no_accept", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // ser_en strobes while idle change nothing
      for (int i = 0; i < 3; i++) begin
         ser_en = 1'b1;
         @(negedge clk);
         chk_all("idle_en", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      ser_en = 1'b0;

      // Full-rate word, then every-3rd-cycle strobe
      send(8'hA5, 0, 1'b0, 8'h00, -1);
      send(8'h81, 3, 1'b0, 8'h00, -1);

      // New word offered mid-word; accepted only after done
      send(8'h3C, 0, 1'b1, 8'hFF, -1);
      send(8'hFF, 0, 1'b0, 8'h00, -1);

      // Reset after 4 bits, then a clean word
      send(8'hC3, 0, 1'b0, 8'h00, 4);
      @(negedge clk);
      chk_all("no_done_after_abort", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      send(8'h5A, 2, 1'b0, 8'h00, -1);

      // Random words with random strobes
      for (int i = 0; i < 6; i++) begin
         send(W'($urandom), -1, 1'b0, 8'h00, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
